controller_num_entry: RTL and testbench

- Multi-cycle number-entry sequencer for the calculator controller.
- Accepts decoded keypad digits (0-9; 4'hf = no digit) through a valid/ready handshake and accumulates them into a binary operand: number = number*10 + digit.
- The multiply uses shift-add over two cycles to avoid a multiplier.
- Delivers the finished operand to the controller data stack on commit, and supports clear and digit-count overflow protection.

---
 rtl/controller_num_entry.sv | 162 ++++++++++++++++
 tb/tb_controller_num_entry.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_num_entry.sv
// controller_num_entry
// Number-entry sequencer for the calculator controller. Keypad digits arrive
// through a valid/ready handshake and are folded into a binary operand as
// number = number*10 + digit. The multiply by ten is split over two cycles
// (x8 in IDLE, +x2 in SHIFT, +digit in ADD) so no multiplier is needed.
// Commit emits the operand as a one-cycle pulse; clear discards it; digits
// beyond MAX_DIGITS are rejected and flagged with a sticky overflow bit.

module controller_num_entry #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 9,
  parameter int CNT_W      = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_clear,
  input  logic             in_commit,
  output logic [WIDTH-1:0] number,
  output logic [CNT_W-1:0] num_count,
  output logic             overflow,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ADD   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Registered state
  state_t             r_state;
  logic [WIDTH-1:0]   r_number;
  logic [WIDTH-1:0]   r_tmp;
  logic [3:0]         r_dreg;
  logic [CNT_W-1:0]   r_num_count;
  logic               r_overflow;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;

  // Next-state values
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_number_nxt;
  logic [WIDTH-1:0]   w_tmp_nxt;
  logic [3:0]         w_dreg_nxt;
  logic [CNT_W-1:0]   w_num_count_nxt;
  logic               w_overflow_nxt;
  logic               w_out_valid_nxt;
  logic [WIDTH-1:0]   w_out_data_nxt;

  logic               w_ready;
  logic               w_accept;
  logic               w_digit_ok;
  logic               w_room;
  logic               w_leading_zero;

  // Ready only in IDLE and out of reset, so a request is never taken on a reset edge
  assign w_ready        = (r_state == ST_IDLE) && Reset;
  assign w_accept       = in_valid && w_ready;
  assign w_digit_ok     = (in_digit <= 4'd9);
  assign w_room         = (r_num_count < MAX_CNT);
  // A zero appended to an empty operand is a leading zero and is not counted
  assign w_leading_zero = (r_number == {WIDTH{1'b0}}) && (r_dreg == 4'd0);

  assign in_ready  = w_ready;
  assign number    = r_number;
  assign num_count = r_num_count;
  assign overflow  = r_overflow;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // State register: synchronous active-low reset discards any partial result
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_number    <= {WIDTH{1'b0}};
      r_tmp       <= {WIDTH{1'b0}};
      r_dreg      <= 4'd0;
      r_num_count <= {CNT_W{1'b0}};
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= {WIDTH{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_number    <= w_number_nxt;
      r_tmp       <= w_tmp_nxt;
      r_dreg      <= w_dreg_nxt;
      r_num_count <= w_num_count_nxt;
      r_overflow  <= w_overflow_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

  // Next-state logic: request decode in IDLE (clear > commit > digit), shift-add in SHIFT/ADD
  always_comb begin
    w_state_nxt     = r_state;
    w_number_nxt    = r_number;
    w_tmp_nxt       = r_tmp;
    w_dreg_nxt      = r_dreg;
    w_num_count_nxt = r_num_count;
    w_overflow_nxt  = r_overflow;
    w_out_valid_nxt = 1'b0;
    w_out_data_nxt  = r_out_data;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (in_clear) begin
            w_number_nxt    = {WIDTH{1'b0}};
            w_num_count_nxt = {CNT_W{1'b0}};
            w_overflow_nxt  = 1'b0;
          end else if (in_commit) begin
            w_out_data_nxt  = r_number;
            w_out_valid_nxt = 1'b1;
            w_number_nxt    = {WIDTH{1'b0}};
            w_num_count_nxt = {CNT_W{1'b0}};
            w_overflow_nxt  = 1'b0;
          end else if (w_digit_ok) begin
            if (w_room) begin
              w_dreg_nxt  = in_digit;
              w_tmp_nxt   = r_number << 3;
              w_state_nxt = ST_SHIFT;
            end else begin
              w_overflow_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        w_tmp_nxt   = r_tmp + (r_number << 1);
        w_state_nxt = ST_ADD;
      end

      ST_ADD: begin
        w_number_nxt = r_tmp + WIDTH'(r_dreg);
        if (!w_leading_zero) begin
          w_num_count_nxt = r_num_count + CNT_ONE;
        end else begin
          w_num_count_nxt = r_num_count;
        end
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_controller_num_entry.sv
// Self-checking bench for controller_num_entry: a reference model tracks the
// operand, and committed operands go through a queue checked by an output monitor.

module tb_controller_num_entry;

  localparam int WIDTH = 32;
  localparam int MAXD  = 9;
  localparam int CNT_W = 4;

  logic             Clock;
  logic             Reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_digit;
  logic             in_clear;
  logic             in_commit;
  logic [WIDTH-1:0] number;
  logic [CNT_W-1:0] num_count;
  logic             overflow;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  int n_pass  = 0;
  int n_total = 0;

  logic [WIDTH-1:0] m_number;
  int               m_count;
  logic             m_overflow;
  logic [WIDTH-1:0] exp_q[$];

  controller_num_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_digit(in_digit), .in_clear(in_clear), .in_commit(in_commit),
    .number(number), .num_count(num_count), .overflow(overflow),
    .out_valid(out_valid), .out_data(out_data)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Output monitor: every out_valid must match the oldest queued commit
  always @(posedge Clock) begin
    #1;
    if (out_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL out_unexpected: out_valid=1 data=%0d, required no output", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) $display("FAIL out_data: got %0d required %0d", out_data, e);
        else n_pass++;
      end
    end
  end

  // Present a request at a negedge, hold until accepted, return at the next negedge
  task automatic send(input logic [3:0] d, input logic clr, input logic cmt);
    int n;
    in_valid = 1'b1; in_digit = d; in_clear = clr; in_commit = cmt;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 20) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
    end
    @(posedge Clock);
    @(negedge Clock);
    in_valid = 1'b0; in_digit = 4'hf; in_clear = 1'b0; in_commit = 1'b0;
  endtask

  // Enter one digit and check handshake latency plus the resulting operand
  task automatic enter_digit(input logic [3:0] d);
    logic [WIDTH-1:0] old_num;
    logic             room;
    old_num = m_number;
    room = (m_count < MAXD);
    send(d, 1'b0, 1'b0);
    if (room) begin
      if (!(m_number == 0 && d == 4'd0)) m_count++;
      m_number = m_number * 10 + WIDTH'(d);
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL busy_shift: in_ready=%b required 0", in_ready);
      else n_pass++;
      @(negedge Clock);
      n_total++;
      if (in_ready !== 1'b0 || number !== old_num)
        $display("FAIL busy_add: in_ready=%b number=%0d required 0/%0d", in_ready, number, old_num);
      else n_pass++;
      @(negedge Clock);
    end else begin
      m_overflow = 1'b1;
    end
    n_total++;
    if (in_ready !== 1'b1 || number !== m_number || num_count !== CNT_W'(m_count) || overflow !== m_overflow)
      $display("FAIL digit_%0d: ready=%b number=%0d count=%0d ovf=%b required 1/%0d/%0d/%b",
               d, in_ready, number, num_count, overflow, m_number, m_count, m_overflow);
    else n_pass++;
  endtask

  // Commit: queue the expected operand, check the pulse shape and the cleared entry
  task automatic do_commit;
    exp_q.push_back(m_number);
    send(4'hf, 1'b0, 1'b1);
    m_number = '0; m_count = 0; m_overflow = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || number !== '0 || num_count !== '0 || overflow !== 1'b0)
      $display("FAIL commit: out_valid=%b number=%0d count=%0d ovf=%b required 1/0/0/0",
               out_valid, number, num_count, overflow);
    else n_pass++;
    @(negedge Clock);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL pulse_width: out_valid=%b required 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    n_total++;
    if (number !== '0 || num_count !== '0 || overflow !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== '0 || in_ready !== 1'b0)
      $display("FAIL reset: number=%0d count=%0d ovf=%b ov=%b od=%0d ready=%b required 0s",
               number, num_count, overflow, out_valid, out_data, in_ready);
    else n_pass++;
    Reset = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", in_ready);
    else n_pass++;
    @(negedge Clock);
  endtask

  task automatic test_basic_entry;
    enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3);
    n_total++;
    if (number !== 32'd123) $display("FAIL basic_123: got %0d required 123", number);
    else n_pass++;
    do_commit();
  endtask

  task automatic test_leading_zeros;
    enter_digit(4'd0); enter_digit(4'd0); enter_digit(4'd7);
    n_total++;
    if (number !== 32'd7 || num_count !== 4'd1)
      $display("FAIL leading_zeros: number=%0d count=%0d required 7/1", number, num_count);
    else n_pass++;
    do_commit();
    do_commit();  // empty commit emits 0
  endtask

  task automatic test_overflow;
    for (int i = 0; i < MAXD; i++) enter_digit(4'd9);
    n_total++;
    if (number !== 32'd999999999 || num_count !== 4'd9)
      $display("FAIL nine_nines: number=%0d count=%0d required 999999999/9", number, num_count);
    else n_pass++;
    enter_digit(4'd5);
    send(4'hf, 1'b1, 1'b0);
    m_number = '0; m_count = 0; m_overflow = 1'b0;
    n_total++;
    if (number !== '0 || num_count !== '0 || overflow !== 1'b0)
      $display("FAIL clear: number=%0d count=%0d ovf=%b required 0/0/0", number, num_count, overflow);
    else n_pass++;
  endtask

  task automatic test_priority;
    enter_digit(4'd5); enter_digit(4'd6);
    send(4'd4, 1'b1, 1'b1);
    m_number = '0; m_count = 0; m_overflow = 1'b0;
    n_total++;
    if (number !== '0 || num_count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL priority: number=%0d count=%0d out_valid=%b ready=%b required 0/0/0/1",
               number, num_count, out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    enter_digit(4'd5);
    send(4'd8, 1'b0, 1'b0);  // now in SHIFT
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    m_number = '0; m_count = 0; m_overflow = 1'b0;
    n_total++;
    if (in_ready !== 1'b1 || number !== '0 || num_count !== '0)
      $display("FAIL reset_mid_op: ready=%b number=%0d count=%0d required 1/0/0",
               in_ready, number, num_count);
    else n_pass++;
    @(negedge Clock);
    n_total++;
    if (number !== '0) $display("FAIL reset_no_resume: number=%0d required 0", number);
    else n_pass++;
  endtask

  task automatic test_invalid_and_busy;
    enter_digit(4'd4);
    send(4'hf, 1'b0, 1'b0);
    n_total++;
    if (in_ready !== 1'b1 || number !== 32'd4 || num_count !== 4'd1)
      $display("FAIL invalid_digit: ready=%b number=%0d count=%0d required 1/4/1",
               in_ready, number, num_count);
    else n_pass++;
    send(4'd12, 1'b0, 1'b0);
    n_total++;
    if (number !== 32'd4 || num_count !== 4'd1)
      $display("FAIL digit_12: number=%0d count=%0d required 4/1", number, num_count);
    else n_pass++;
    // Digit 3 requested while digit 2 is still in flight: must wait for ready
    send(4'd2, 1'b0, 1'b0);
    m_number = 32'd42; m_count = 2;
    in_valid = 1'b1; in_digit = 4'd3;
    @(negedge Clock);
    n_total++;
    if (number !== 32'd4) $display("FAIL busy_hold: number=%0d required 4", number);
    else n_pass++;
    @(negedge Clock);
    n_total++;
    if (number !== 32'd42 || in_ready !== 1'b1)
      $display("FAIL after_2: number=%0d ready=%b required 42/1", number, in_ready);
    else n_pass++;
    enter_digit(4'd3);
    do_commit();
  endtask

  initial begin
    Reset = 1'b0; in_valid = 1'b0; in_digit = 4'hf; in_clear = 1'b0; in_commit = 1'b0;
    m_number = '0; m_count = 0; m_overflow = 1'b0;
    @(negedge Clock);
    test_reset();
    test_basic_entry();
    test_leading_zeros();
    test_overflow();
    test_priority();
    test_reset_mid_op();
    test_invalid_and_busy();
    repeat (3) @(negedge Clock);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d outputs missing, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
